// File: rtl/fir_cfg_ctrl_if.sv
// Coefficient-load / decimator-control bus for fir_cfg_ctrl.
// The master drives the configuration stream; the slave (the controller)
// drives the coefficient write port, run enable, strobes and status.
interface fir_cfg_ctrl_if #(
    parameter int NTAPS      = 256,
    parameter int COEFF_SIZE = 16
);
    localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    logic                  cfg_start;
    logic                  cfg_valid;
    logic [COEFF_SIZE-1:0] cfg_data;
    logic                  cfg_ready;
    logic                  c_we;
    logic [AW-1:0]         c_addr;
    logic [COEFF_SIZE-1:0] c_in;
    logic                  fir_en;
    logic                  in_stb;
    logic                  out_stb;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output cfg_start, cfg_valid, cfg_data,
        input  cfg_ready, c_we, c_addr, c_in, fir_en, in_stb, out_stb, busy, done, err
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data,
        output cfg_ready, c_we, c_addr, c_in, fir_en, in_stb, out_stb, busy, done, err
    );
endinterface

// File: rtl/fir_cfg_ctrl.sv
// FIR decimator configuration controller.
// IDLE -> LOAD streams NTAPS coefficients into the decimator's coefficient
// memory; LOAD -> RUN enables the filter and generates the input/output
// sample strobes. A stalled load times out back to IDLE with a sticky err.
// Every output is a flop; cfg_start always wins and restarts a load.
module fir_cfg_ctrl #(
    parameter int NTAPS      = 256,
    parameter int M          = 8,
    parameter int D          = 100,
    parameter int COEFF_SIZE = 16,
    parameter int TMO        = 1024
) (
    input  logic          clk,
    input  logic          nrst,
    fir_cfg_ctrl_if.slave bus
);
    localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int DW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = (M > 1) ? $clog2(M) : 1;
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         idle_q, idle_d;
    logic [DW-1:0]         div_q, div_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic                  c_we_q, c_we_d;
    logic [AW-1:0]         c_addr_q, c_addr_d;
    logic [COEFF_SIZE-1:0] c_in_q, c_in_d;
    logic                  fir_en_q, fir_en_d;
    logic                  in_stb_q, in_stb_d;
    logic                  out_stb_q, out_stb_d;
    logic                  cfg_ready_q, cfg_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  hs_s;

    // A word is accepted only while the registered ready is high (LOAD only).
    assign hs_s = bus.cfg_valid & cfg_ready_q;

    // Next-state and next-output logic: start/restart first, then per-state behaviour.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        div_d       = div_q;
        phase_d     = phase_q;
        c_we_d      = 1'b0;
        c_addr_d    = c_addr_q;
        c_in_d      = c_in_q;
        fir_en_d    = fir_en_q;
        in_stb_d    = 1'b0;
        out_stb_d   = 1'b0;
        cfg_ready_d = cfg_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;

        if (bus.cfg_start) begin
            // Any word offered in this cycle is dropped; the load restarts at 0.
            state_d     = S_LOAD;
            cnt_d       = '0;
            idle_d      = '0;
            div_d       = '0;
            phase_d     = '0;
            fir_en_d    = 1'b0;
            cfg_ready_d = 1'b1;
            busy_d      = 1'b1;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (hs_s) begin
                        c_we_d   = 1'b1;
                        c_addr_d = cnt_q;
                        c_in_d   = bus.cfg_data;
                        idle_d   = '0;
                        if (cnt_q == AW'(NTAPS - 1)) begin
                            // Last coefficient: stop accepting and hand over to RUN.
                            state_d     = S_RUN;
                            cnt_d       = '0;
                            div_d       = '0;
                            phase_d     = '0;
                            cfg_ready_d = 1'b0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                        end else begin
                            cnt_d = cnt_q + AW'(1);
                        end
                    end else if (idle_q == TW'(TMO - 1)) begin
                        // Source stalled too long: abandon the load.
                        state_d     = S_IDLE;
                        cfg_ready_d = 1'b0;
                        busy_d      = 1'b0;
                        err_d       = 1'b1;
                    end else begin
                        idle_d = idle_q + TW'(1);
                    end
                end
                S_RUN: begin
                    // fir_en rises one cycle after RUN entry; the divider starts with it.
                    fir_en_d    = 1'b1;
                    cfg_ready_d = 1'b0;
                    busy_d      = 1'b0;
                    if (fir_en_q) begin
                        if (div_q == DW'(D - 1)) begin
                            div_d    = '0;
                            in_stb_d = 1'b1;
                            if (phase_q == PW'(M - 1)) begin
                                phase_d   = '0;
                                out_stb_d = 1'b1;
                            end else begin
                                phase_d = phase_q + PW'(1);
                            end
                        end else begin
                            div_d = div_q + DW'(1);
                        end
                    end else begin
                        div_d = '0;
                    end
                end
                S_IDLE: begin
                    fir_en_d    = 1'b0;
                    cfg_ready_d = 1'b0;
                    busy_d      = 1'b0;
                end
                default: begin
                    state_d     = S_IDLE;
                    fir_en_d    = 1'b0;
                    cfg_ready_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs; nrst clears everything at once.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idle_q      <= '0;
            div_q       <= '0;
            phase_q     <= '0;
            c_we_q      <= 1'b0;
            c_addr_q    <= '0;
            c_in_q      <= '0;
            fir_en_q    <= 1'b0;
            in_stb_q    <= 1'b0;
            out_stb_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            c_we_q      <= c_we_d;
            c_addr_q    <= c_addr_d;
            c_in_q      <= c_in_d;
            fir_en_q    <= fir_en_d;
            in_stb_q    <= in_stb_d;
            out_stb_q   <= out_stb_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.c_we      = c_we_q;
    assign bus.c_addr    = c_addr_q;
    assign bus.c_in      = c_in_q;
    assign bus.fir_en    = fir_en_q;
    assign bus.in_stb    = in_stb_q;
    assign bus.out_stb   = out_stb_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Directed bench for fir_cfg_ctrl: coefficient writes are checked through a
// scoreboard queue, control/status outputs through directed comparisons.
module tb_fir_cfg_ctrl;
    localparam int NTAPS = 256;
    localparam int M     = 8;
    localparam int D     = 100;
    localparam int CW    = 16;
    localparam int TMO   = 1024;

    typedef struct {
        logic [7:0]    addr;
        logic [CW-1:0] data;
    } wr_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   addr_m = 0;
    wr_t  q[$];

    fir_cfg_ctrl_if #(.NTAPS(NTAPS), .COEFF_SIZE(CW)) bus ();

    fir_cfg_ctrl #(.NTAPS(NTAPS), .M(M), .D(D), .COEFF_SIZE(CW), .TMO(TMO)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every coefficient write must match the oldest expected write.
    always @(negedge clk) begin
        if (nrst && bus.c_we) begin
            if (q.size() == 0) begin
                chk("unexpected_write", bus.c_we, 1'b0);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("c_addr", bus.c_addr, e.addr);
                chk("c_in", bus.c_in, e.data);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_c_we"}, bus.c_we, 1'b0);
        chk({tag, "_c_addr"}, bus.c_addr, 8'd0);
        chk({tag, "_c_in"}, bus.c_in, 16'd0);
        chk({tag, "_fir_en"}, bus.fir_en, 1'b0);
        chk({tag, "_in_stb"}, bus.in_stb, 1'b0);
        chk({tag, "_out_stb"}, bus.out_stb, 1'b0);
        chk({tag, "_cfg_ready"}, bus.cfg_ready, 1'b0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_done"}, bus.done, 1'b0);
        chk({tag, "_err"}, bus.err, 1'b0);
    endtask

    task automatic start();
        bus.cfg_start = 1'b1;
        addr_m = 0;
        tick();
        bus.cfg_start = 1'b0;
        chk("start_ready", bus.cfg_ready, 1'b1);
        chk("start_busy", bus.busy, 1'b1);
        chk("start_fir_en", bus.fir_en, 1'b0);
        chk("start_in_stb", bus.in_stb, 1'b0);
        chk("start_err", bus.err, 1'b0);
    endtask

    // One accepted word; the write it causes is queued for the scoreboard.
    task automatic send(input logic [CW-1:0] d, input bit last);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = d;
        q.push_back('{addr: 8'(addr_m), data: d});
        addr_m++;
        tick();
        bus.cfg_valid = 1'b0;
        chk("done", bus.done, last);
        chk("ready_after_word", bus.cfg_ready, !last);
    endtask

    initial begin
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        nrst = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 16'hDEAD;
        for (int i = 0; i < 4; i++) tick();
        chk("idle_ignores_valid_ready", bus.cfg_ready, 1'b0);
        bus.cfg_valid = 1'b0;

        // Full back-to-back load, value = address
        start();
        for (int i = 0; i < NTAPS; i++) send(CW'(i), i == NTAPS - 1);
        chk("full_fir_en_before", bus.fir_en, 1'b0);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 16'h5555;
        tick();
        bus.cfg_valid = 1'b0;
        chk("full_fir_en_rise", bus.fir_en, 1'b1);
        chk("full_done_clear", bus.done, 1'b0);

        // Strobes: in_stb every D cycles after fir_en, out_stb on every M-th
        for (int k = 1; k <= 2 * M * D; k++) begin
            tick();
            chk("in_stb", bus.in_stb, (k % D) == 0);
            chk("out_stb", bus.out_stb, (k % (M * D)) == 0);
        end
        chk("run_fir_en_held", bus.fir_en, 1'b1);

        // Stalled source: valid toggles, load started from RUN
        start();
        for (int i = 0; i < NTAPS; i++) begin
            send(CW'(i * 3 + 7), i == NTAPS - 1);
            tick();
            chk("stall_gap_c_we", bus.c_we, 1'b0);
            if (i == NTAPS - 1) chk("stall_fir_en", bus.fir_en, 1'b1);
            else chk("stall_fir_en_low", bus.fir_en, 1'b0);
        end

        // Timeout after 10 words
        start();
        for (int i = 0; i < 10; i++) send(CW'(16'hA000 + i), 1'b0);
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("tmo_err_early", bus.err, 1'b0);
        chk("tmo_busy_early", bus.busy, 1'b1);
        tick();
        chk("tmo_err", bus.err, 1'b1);
        chk("tmo_busy", bus.busy, 1'b0);
        chk("tmo_ready", bus.cfg_ready, 1'b0);
        chk("tmo_fir_en", bus.fir_en, 1'b0);
        chk("tmo_done", bus.done, 1'b0);
        bus.cfg_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.cfg_valid = 1'b0;
        chk("tmo_err_sticky", bus.err, 1'b1);

        // Restart during word 50 (start() also checks err clears on LOAD entry)
        start();
        for (int i = 0; i < 50; i++) send(CW'(16'h2000 + i), 1'b0);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 16'hBEEF;
        bus.cfg_start = 1'b1;
        addr_m = 0;
        tick();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        chk("restart_c_we", bus.c_we, 1'b0);
        chk("restart_busy", bus.busy, 1'b1);
        for (int i = 0; i < NTAPS; i++) begin
            send(CW'(16'h1000 + i), i == NTAPS - 1);
            chk("restart_fir_en_low", bus.fir_en, 1'b0);
        end
        tick();
        chk("restart_fir_en", bus.fir_en, 1'b1);

        // Reset at word 100
        start();
        for (int i = 0; i < 100; i++) send(CW'(16'h3000 + i), 1'b0);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 16'h7777;
        @(negedge clk);
        #1;
        nrst = 1'b0;
        #1;
        check_all_zero("midload_reset");
        tick();
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_reset_ready", bus.cfg_ready, 1'b0);
        chk("post_reset_fir_en", bus.fir_en, 1'b0);
        bus.cfg_valid = 1'b0;
        start();
        for (int i = 0; i < NTAPS; i++) send(CW'(16'hFFFF - i), i == NTAPS - 1);
        tick();
        chk("reload_fir_en", bus.fir_en, 1'b1);

        tick();
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
